ecg_window_scan_sched: RTL and testbench

- Arbitrates four window-search requesters (P, T, Q, S) onto the single read port of the 800-sample ECG buffer.
- Sequences one max/min scan at a time over the granted [begin, end] window and returns extreme values and positions to the requester.
- Replaces per-feature parallel scanners, so the feature extractor needs one comparator pair and one memory port.

---
 rtl/ecg_window_scan_sched_pkg.sv | 29 ++
 rtl/ecg_rr_arbiter.sv | 48 ++++
 rtl/ecg_window_scan_sched.sv | 175 +++++++++++++++++
 tb/tb_ecg_window_scan_sched.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecg_window_scan_sched_pkg.sv
// Shared constants for the ECG window scan scheduler: buffer geometry, requester
// indices and FSM state encodings.
package ecg_window_scan_sched_pkg;

   localparam int unsigned NSAMP = 800;
   localparam int unsigned AW    = 12;
   localparam int unsigned DW    = 17;
   localparam int unsigned NREQ  = 4;

   localparam logic [1:0] REQ_P = 2'd0;
   localparam logic [1:0] REQ_T = 2'd1;
   localparam logic [1:0] REQ_Q = 2'd2;
   localparam logic [1:0] REQ_S = 2'd3;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StScan  = 3'd1;
   localparam logic [2:0] StDrain = 3'd2;
   localparam logic [2:0] StDone  = 3'd3;
   localparam logic [2:0] StErr   = 3'd4;

   typedef logic        [AW-1:0] addr_t;
   typedef logic signed [DW-1:0] samp_t;

   // A window is scannable when ordered and fully inside the buffer.
   function automatic logic win_legal(input addr_t b, input addr_t e);
      return (b <= e) && (e <= addr_t'(NSAMP - 1));
   endfunction

endpackage

// File: rtl/ecg_rr_arbiter.sv
// Round-robin arbiter: combinational grant searched from a registered pointer that
// moves to one past the winner whenever a grant is taken.
module ecg_rr_arbiter #(
   parameter  int unsigned NReq = 4,
   localparam int unsigned IdxW = $clog2(NReq)
) (
   input  logic            clk,
   input  logic            nReset,
   input  logic [NReq-1:0] req_i,
   input  logic            en_i,
   output logic [NReq-1:0] gnt_o,
   output logic [IdxW-1:0] gnt_idx_o,
   output logic            gnt_valid_o
);

   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] cand;
   logic            found;

   always_comb begin
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < NReq; k++) begin
         cand = IdxW'((ptr_q + k) % NReq);
         if (!found && req_i[cand]) begin
            found     = 1'b1;
            gnt_idx_o = cand;
         end
      end
      gnt_valid_o         = found & en_i;
      gnt_o               = '0;
      gnt_o[gnt_idx_o]    = gnt_valid_o;
      ptr_d               = ptr_q;
      if (gnt_valid_o) begin
         ptr_d = (gnt_idx_o == IdxW'(NReq - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/ecg_window_scan_sched.sv
// Shares one ECG buffer read port between the P/T/Q/S window searches, running one
// max/min scan at a time and returning extremes and their positions.
module ecg_window_scan_sched
   import ecg_window_scan_sched_pkg::*;
(
   input  logic               clk,
   input  logic               nReset,
   input  logic               Enable,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_begin,
   input  logic [NREQ*AW-1:0] req_end,
   output logic [NREQ-1:0]    req_ack,
   output logic               mem_rd_en,
   output logic [AW-1:0]      mem_addr,
   input  logic [DW-1:0]      mem_rd_data,
   output logic               res_valid,
   output logic [1:0]         res_id,
   output logic               res_err,
   output logic [DW-1:0]      res_max_val,
   output logic [AW-1:0]      res_max_pos,
   output logic [DW-1:0]      res_min_val,
   output logic [AW-1:0]      res_min_pos,
   output logic               busy
);

   logic [2:0]      state_q, state_d;
   addr_t           beg_q, end_q, addr_q, pos_q;
   logic [1:0]      id_q;
   logic            rd_pend_q;
   samp_t           trk_max_q, trk_max_d, trk_min_q, trk_min_d;
   addr_t           trk_max_pos_q, trk_max_pos_d, trk_min_pos_q, trk_min_pos_d;
   logic [1:0]      hold_id_q;
   logic            hold_err_q;
   logic [DW-1:0]   hold_max_q, hold_min_q;
   addr_t           hold_max_pos_q, hold_min_pos_q;

   logic [NREQ-1:0] gnt;
   logic [1:0]      gnt_idx;
   logic            gnt_valid, arb_en, win_ok;
   addr_t           win_beg, win_end;
   samp_t           rd_s;

   assign arb_en  = (state_q == StIdle) && Enable;
   assign win_beg = req_begin[gnt_idx*AW +: AW];
   assign win_end = req_end[gnt_idx*AW +: AW];
   assign win_ok  = win_legal(win_beg, win_end);
   assign rd_s    = samp_t'(mem_rd_data);

   ecg_rr_arbiter #(
      .NReq (NREQ)
   ) u_arb (
      .clk         (clk),
      .nReset      (nReset),
      .req_i       (req_valid),
      .en_i        (arb_en),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   assign req_ack   = gnt;
   assign mem_rd_en = (state_q == StScan) && Enable;
   assign mem_addr  = addr_q;
   assign busy      = (state_q != StIdle);
   assign res_valid = Enable && ((state_q == StDone) || (state_q == StErr));

   always_comb begin
      state_d = state_q;
      if (!Enable) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:        if (gnt_valid) state_d = win_ok ? StScan : StErr;
            StScan:        if (addr_q == end_q) state_d = StDrain;
            StDrain:       state_d = StDone;
            StDone, StErr: state_d = StIdle;
            default:       state_d = StIdle;
         endcase
      end
   end

   // Data arrives one cycle after its address; the word at the window start seeds both.
   always_comb begin
      trk_max_d     = trk_max_q;
      trk_max_pos_d = trk_max_pos_q;
      trk_min_d     = trk_min_q;
      trk_min_pos_d = trk_min_pos_q;
      if (rd_pend_q) begin
         if ((pos_q == beg_q) || (rd_s > trk_max_q)) begin
            trk_max_d     = rd_s;
            trk_max_pos_d = pos_q;
         end
         if ((pos_q == beg_q) || (rd_s < trk_min_q)) begin
            trk_min_d     = rd_s;
            trk_min_pos_d = pos_q;
         end
      end
   end

   always_comb begin
      res_id      = hold_id_q;
      res_err     = hold_err_q;
      res_max_val = hold_max_q;
      res_max_pos = hold_max_pos_q;
      res_min_val = hold_min_q;
      res_min_pos = hold_min_pos_q;
      if (Enable && (state_q == StDone)) begin
         res_id      = id_q;
         res_err     = 1'b0;
         res_max_val = trk_max_q;
         res_max_pos = trk_max_pos_q;
         res_min_val = trk_min_q;
         res_min_pos = trk_min_pos_q;
      end else if (Enable && (state_q == StErr)) begin
         res_id      = id_q;
         res_err     = 1'b1;
         res_max_val = '0;
         res_max_pos = '0;
         res_min_val = '0;
         res_min_pos = '0;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q        <= StIdle;
         beg_q          <= '0;
         end_q          <= '0;
         addr_q         <= '0;
         pos_q          <= '0;
         id_q           <= '0;
         rd_pend_q      <= 1'b0;
         trk_max_q      <= '0;
         trk_max_pos_q  <= '0;
         trk_min_q      <= '0;
         trk_min_pos_q  <= '0;
         hold_id_q      <= '0;
         hold_err_q     <= 1'b0;
         hold_max_q     <= '0;
         hold_max_pos_q <= '0;
         hold_min_q     <= '0;
         hold_min_pos_q <= '0;
      end else begin
         state_q       <= state_d;
         rd_pend_q     <= mem_rd_en;
         trk_max_q     <= trk_max_d;
         trk_max_pos_q <= trk_max_pos_d;
         trk_min_q     <= trk_min_d;
         trk_min_pos_q <= trk_min_pos_d;
         if (gnt_valid) begin
            beg_q <= win_beg;
            end_q <= win_end;
            id_q  <= gnt_idx;
         end
         // Address only moves on a legal grant or while reading, so it holds otherwise.
         if (gnt_valid && win_ok) begin
            addr_q <= win_beg;
         end else if (mem_rd_en && (addr_q != end_q)) begin
            addr_q <= addr_q + 1'b1;
         end
         if (mem_rd_en) begin
            pos_q <= addr_q;
         end
         if (res_valid) begin
            hold_id_q      <= res_id;
            hold_err_q     <= res_err;
            hold_max_q     <= res_max_val;
            hold_max_pos_q <= res_max_pos;
            hold_min_q     <= res_min_val;
            hold_min_pos_q <= res_min_pos;
         end
      end
   end

endmodule

// File: tb/tb_ecg_window_scan_sched.sv
// Bench for ecg_window_scan_sched: random windows and buffer contents checked against
// a behavioural scheduler/scan model.
module tb_ecg_window_scan_sched;

   localparam int NSAMP = 800;
   localparam int AW    = 12;
   localparam int DW    = 17;

   logic             clk = 1'b0;
   logic             nReset, Enable;
   logic [3:0]       req_valid;
   logic [4*AW-1:0]  req_begin, req_end;
   logic [3:0]       req_ack;
   logic             mem_rd_en;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_rd_data;
   logic             res_valid, res_err, busy;
   logic [1:0]       res_id;
   logic [DW-1:0]    res_max_val, res_min_val;
   logic [AW-1:0]    res_max_pos, res_min_pos;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int model_ptr = 0;
   int wb[4];
   int we[4];
   logic signed [DW-1:0] mem [NSAMP];

   typedef struct {int cyc; int id; bit onehot;} ack_t;
   typedef struct {int cyc; int id; bit err; int mx; int mxp; int mn; int mnp;} res_t;
   ack_t ack_log[$];
   res_t res_log[$];
   int   rd_log[$];

   always #5 clk = ~clk;

   ecg_window_scan_sched dut (
      .clk         (clk),
      .nReset      (nReset),
      .Enable      (Enable),
      .req_valid   (req_valid),
      .req_begin   (req_begin),
      .req_end     (req_end),
      .req_ack     (req_ack),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .res_valid   (res_valid),
      .res_id      (res_id),
      .res_err     (res_err),
      .res_max_val (res_max_val),
      .res_max_pos (res_max_pos),
      .res_min_val (res_min_val),
      .res_min_pos (res_min_pos),
      .busy        (busy)
   );

   // Buffer model with one-cycle read latency, plus a log of issued addresses.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd_en) begin
         rd_log.push_back(int'(mem_addr));
         mem_rd_data <= (int'(mem_addr) < NSAMP) ? mem[mem_addr] : '0;
      end
   end

   function automatic bit legal(input int b, input int e);
      return (b <= e) && (e <= NSAMP - 1);
   endfunction

   function automatic void ref_scan(input int b, input int e, output int mx, output int mxp,
                                    output int mn, output int mnp);
      mx = mem[b]; mxp = b; mn = mem[b]; mnp = b;
      for (int a = b + 1; a <= e; a++) begin
         if (int'(mem[a]) > mx) begin mx = mem[a]; mxp = a; end
         if (int'(mem[a]) < mn) begin mn = mem[a]; mnp = a; end
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      nReset = 1'b0;
      step();
      step();
      nReset = 1'b1;
      model_ptr = 0;
      step();
   endtask

   task automatic set_win(input int id, input int b, input int e);
      req_begin[id*AW +: AW] = AW'(b);
      req_end[id*AW +: AW]   = AW'(e);
      wb[id] = b;
      we[id] = e;
   endtask

   task automatic fill_mem(input bit ties);
      for (int i = 0; i < NSAMP; i++)
         mem[i] = ties ? DW'($urandom_range(0, 4)) - DW'(2) : DW'($urandom);
   endtask

   task automatic gen_windows(input bit legal_only);
      int b, e, len;
      for (int i = 0; i < 4; i++) begin
         if (!legal_only && $urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 0) begin
               b = $urandom_range(1, NSAMP - 1); e = $urandom_range(0, b - 1);
            end else begin
               b = $urandom_range(0, NSAMP - 1); e = $urandom_range(NSAMP, 4095);
            end
         end else begin
            len = $urandom_range(1, 12);
            b = $urandom_range(0, NSAMP - len); e = b + len - 1;
         end
         set_win(i, b, e);
      end
   endtask

   // Records acks/results each cycle and withdraws a requester once acked.
   task automatic run_sched(input int n_res, input int budget, output bit timeout);
      ack_t a;
      res_t r;
      logic [3:0] drop;
      timeout = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         drop = req_ack;
         if (req_ack != 0) begin
            a.cyc = cyc; a.onehot = $onehot(req_ack); a.id = -1;
            for (int k = 0; k < 4; k++) if (req_ack[k]) a.id = k;
            ack_log.push_back(a);
         end
         if (res_valid) begin
            r.cyc = cyc; r.id = int'(res_id); r.err = res_err;
            r.mx = int'($signed(res_max_val)); r.mxp = int'(res_max_pos);
            r.mn = int'($signed(res_min_val)); r.mnp = int'(res_min_pos);
            res_log.push_back(r);
         end
         if (res_log.size() >= n_res) begin
            timeout = 1'b0;
            break;
         end
         @(posedge clk);
         #1;
         req_valid = req_valid & ~drop;
      end
      step();
      req_valid = req_valid & ~drop;
   endtask

   task automatic test_reset();
      nReset = 1'b1; Enable = 1'b1; req_valid = '0; req_begin = '0; req_end = '0;
      #2 nReset = 1'b0;
      #1;
      checks++;
      if ({req_ack, mem_rd_en, mem_addr, res_valid, res_id, res_err, res_max_val, res_max_pos,
           res_min_val, res_min_pos} !== '0)
         begin failures++; $display("FAIL reset_outputs: outputs not all zero under reset"); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      step();
      nReset = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0)
         begin failures++; $display("FAIL reset_idle: busy=%b res_valid=%b want 0", busy, res_valid); end
      step();
   endtask

   task automatic test_single_t();
      bit to;
      int exp_rd[$] = '{100, 101, 102, 103, 104};
      mem[100] = -5; mem[101] = 7; mem[102] = 7; mem[103] = -9; mem[104] = 3;
      set_win(1, 100, 104);
      ack_log.delete(); res_log.delete(); rd_log.delete();
      req_valid = 4'b0010;
      run_sched(1, 60, to);
      checks++;
      if (to || ack_log.size() != 1) begin
         failures++; $display("FAIL t_timeout: acks=%0d results=%0d want 1/1", ack_log.size(), res_log.size());
         return;
      end
      checks++;
      if (ack_log[0].id != 1 || !ack_log[0].onehot)
         begin failures++; $display("FAIL t_ack: got id %0d want 1", ack_log[0].id); end
      checks++;
      if (res_log[0].cyc - ack_log[0].cyc != 7)
         begin failures++; $display("FAIL t_latency: got %0d want 7", res_log[0].cyc - ack_log[0].cyc); end
      checks++;
      if (res_log[0].mx != 7 || res_log[0].mxp != 101)
         begin failures++; $display("FAIL t_max: got %0d@%0d want 7@101", res_log[0].mx, res_log[0].mxp); end
      checks++;
      if (res_log[0].mn != -9 || res_log[0].mnp != 103)
         begin failures++; $display("FAIL t_min: got %0d@%0d want -9@103", res_log[0].mn, res_log[0].mnp); end
      checks++;
      if (res_log[0].id != 1 || res_log[0].err)
         begin failures++; $display("FAIL t_id: got id %0d err %0d want 1/0", res_log[0].id, res_log[0].err); end
      checks++;
      if (rd_log != exp_rd) begin failures++; $display("FAIL t_reads: got %p want %p", rd_log, exp_rd); end
      repeat (3) @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || $signed(res_max_val) != 7 || res_min_pos != 103)
         begin failures++; $display("FAIL t_hold: max %0d minpos %0d want 7/103", $signed(res_max_val), res_min_pos); end
      step();
   endtask

   task automatic test_err();
      bit to;
      int ids[2] = '{2, 3};
      int bs[2] = '{200, 5};
      int es[2] = '{150, 800};
      for (int c = 0; c < 2; c++) begin
         set_win(ids[c], bs[c], es[c]);
         ack_log.delete(); res_log.delete(); rd_log.delete();
         req_valid = 4'b0001 << ids[c];
         run_sched(1, 20, to);
         checks++;
         if (to || ack_log.size() != 1) begin
            failures++; $display("FAIL err_timeout: case %0d no result", c);
            continue;
         end
         checks++;
         if (res_log[0].cyc - ack_log[0].cyc != 1)
            begin failures++; $display("FAIL err_latency: got %0d want 1", res_log[0].cyc - ack_log[0].cyc); end
         checks++;
         if (!res_log[0].err || res_log[0].id != ids[c])
            begin failures++; $display("FAIL err_flag: got err %0d id %0d want 1/%0d", res_log[0].err, res_log[0].id, ids[c]); end
         checks++;
         if (res_log[0].mx != 0 || res_log[0].mxp != 0 || res_log[0].mn != 0 || res_log[0].mnp != 0)
            begin failures++; $display("FAIL err_values: got %0d %0d %0d %0d want 0", res_log[0].mx, res_log[0].mxp, res_log[0].mn, res_log[0].mnp); end
         checks++;
         if (rd_log.size() != 0) begin failures++; $display("FAIL err_reads: got %0d reads want 0", rd_log.size()); end
      end
   endtask

   task automatic test_single_sample();
      bit to;
      mem[0] = -65536;
      set_win(0, 0, 0);
      ack_log.delete(); res_log.delete(); rd_log.delete();
      req_valid = 4'b0001;
      run_sched(1, 20, to);
      checks++;
      if (to || ack_log.size() != 1) begin failures++; $display("FAIL one_timeout: no result"); return; end
      checks++;
      if (res_log[0].cyc - ack_log[0].cyc != 3)
         begin failures++; $display("FAIL one_latency: got %0d want 3", res_log[0].cyc - ack_log[0].cyc); end
      checks++;
      if (res_log[0].mx != -65536 || res_log[0].mn != -65536 || res_log[0].mxp != 0 || res_log[0].mnp != 0)
         begin failures++; $display("FAIL one_values: got %0d@%0d %0d@%0d want -65536@0", res_log[0].mx, res_log[0].mxp, res_log[0].mn, res_log[0].mnp); end
   endtask

   task automatic test_rr_batch(input logic [3:0] mask);
      int order[$];
      int exp_rd[$];
      logic [3:0] pend;
      int p, c, lat, mx, mxp, mn, mnp;
      bit to;
      pend = mask; p = model_ptr;
      while (pend != 0) begin
         for (int k = 0; k < 4; k++) begin
            c = (p + k) % 4;
            if (pend[c]) begin order.push_back(c); pend[c] = 1'b0; p = (c + 1) % 4; break; end
         end
      end
      model_ptr = p;
      foreach (order[k])
         if (legal(wb[order[k]], we[order[k]]))
            for (int a = wb[order[k]]; a <= we[order[k]]; a++) exp_rd.push_back(a);
      ack_log.delete(); res_log.delete(); rd_log.delete();
      req_valid = mask;
      run_sched(order.size(), 400, to);
      checks++;
      if (to) begin failures++; $display("FAIL rr_timeout: got %0d results want %0d", res_log.size(), order.size()); end
      for (int k = 0; k < order.size(); k++) begin
         if (k >= ack_log.size() || k >= res_log.size()) break;
         c = order[k];
         checks++;
         if (ack_log[k].id != c || !ack_log[k].onehot)
            begin failures++; $display("FAIL rr_order: grant %0d got id %0d want %0d", k, ack_log[k].id, c); end
         lat = legal(wb[c], we[c]) ? we[c] - wb[c] + 3 : 1;
         checks++;
         if (res_log[k].cyc - ack_log[k].cyc != lat)
            begin failures++; $display("FAIL rr_latency: id %0d got %0d want %0d", c, res_log[k].cyc - ack_log[k].cyc, lat); end
         if (k > 0) begin
            checks++;
            if (ack_log[k].cyc != res_log[k-1].cyc + 1)
               begin failures++; $display("FAIL rr_gap: ack at %0d want %0d", ack_log[k].cyc, res_log[k-1].cyc + 1); end
         end
         if (legal(wb[c], we[c])) ref_scan(wb[c], we[c], mx, mxp, mn, mnp);
         else begin mx = 0; mxp = 0; mn = 0; mnp = 0; end
         checks++;
         if (res_log[k].id != c || res_log[k].err == legal(wb[c], we[c]) || res_log[k].mx != mx ||
             res_log[k].mxp != mxp || res_log[k].mn != mn || res_log[k].mnp != mnp)
            begin
               failures++;
               $display("FAIL rr_result: id %0d err %0d max %0d@%0d min %0d@%0d want id %0d max %0d@%0d min %0d@%0d",
                        res_log[k].id, res_log[k].err, res_log[k].mx, res_log[k].mxp, res_log[k].mn,
                        res_log[k].mnp, c, mx, mxp, mn, mnp);
            end
      end
      checks++;
      if (rd_log != exp_rd)
         begin failures++; $display("FAIL rr_reads: got %0d reads want %0d", rd_log.size(), exp_rd.size()); end
   endtask

   task automatic test_all_four();
      do_reset();
      fill_mem(1'b0);
      gen_windows(1'b1);
      test_rr_batch(4'b1111);
      // Pointer back at P: P must beat T.
      gen_windows(1'b1);
      test_rr_batch(4'b0011);
   endtask

   task automatic test_random();
      logic [3:0] m;
      do_reset();
      for (int r = 0; r < 12; r++) begin
         fill_mem(r[0]);
         gen_windows(1'b0);
         m = 4'($urandom_range(1, 15));
         test_rr_batch(m);
      end
   endtask

   task automatic wait_ack(input int budget, output int idx, output int at);
      idx = -1; at = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (req_ack != 0) begin
            for (int k = 0; k < 4; k++) if (req_ack[k]) idx = k;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_enable_abort();
      int idx, at, mx, mxp, mn, mnp, stray;
      bit to;
      fill_mem(1'b1);
      set_win(2, 10, 60);
      req_valid = 4'b0100;
      wait_ack(10, idx, at);
      checks++;
      if (idx != 2) begin failures++; $display("FAIL abort_ack: got %0d want 2", idx); req_valid = '0; return; end
      repeat (12) step();
      Enable = 1'b0;
      step();
      @(negedge clk);
      checks++;
      if (mem_rd_en !== 1'b0 || busy !== 1'b0)
         begin failures++; $display("FAIL abort_stop: rd_en %b busy %b want 0/0", mem_rd_en, busy); end
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (res_valid || req_ack != 0 || mem_rd_en) stray++;
      end
      checks++;
      if (stray != 0) begin failures++; $display("FAIL abort_quiet: got %0d active cycles want 0", stray); end
      step();
      ack_log.delete(); res_log.delete(); rd_log.delete();
      Enable = 1'b1;
      run_sched(1, 100, to);
      checks++;
      if (to || ack_log.size() != 1) begin failures++; $display("FAIL abort_resume: no result after re-enable"); return; end
      ref_scan(10, 60, mx, mxp, mn, mnp);
      checks++;
      if (ack_log[0].id != 2 || res_log[0].cyc - ack_log[0].cyc != 53 || rd_log.size() != 51 || rd_log[0] != 10)
         begin failures++; $display("FAIL abort_rescan: id %0d latency %0d reads %0d want 2/53/51", ack_log[0].id, res_log[0].cyc - ack_log[0].cyc, rd_log.size()); end
      checks++;
      if (res_log[0].mx != mx || res_log[0].mxp != mxp || res_log[0].mn != mn || res_log[0].mnp != mnp)
         begin failures++; $display("FAIL abort_values: got %0d@%0d %0d@%0d want %0d@%0d %0d@%0d", res_log[0].mx, res_log[0].mxp, res_log[0].mn, res_log[0].mnp, mx, mxp, mn, mnp); end
   endtask

   task automatic test_reset_mid_scan();
      int idx, at, stray, mx, mxp, mn, mnp;
      bit to;
      fill_mem(1'b0);
      set_win(3, 300, 340);
      req_valid = 4'b1000;
      wait_ack(10, idx, at);
      step();
      req_valid = '0;
      repeat (5) step();
      nReset = 1'b0;
      #1;
      checks++;
      if ({req_ack, mem_rd_en, mem_addr, res_valid, res_id, res_err, res_max_val, res_max_pos,
           res_min_val, res_min_pos, busy} !== '0)
         begin failures++; $display("FAIL rst_mid: outputs not all zero, busy=%b rd_en=%b", busy, mem_rd_en); end
      step();
      nReset = 1'b1;
      model_ptr = 0;
      stray = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (res_valid || busy) stray++;
      end
      checks++;
      if (stray != 0) begin failures++; $display("FAIL rst_quiet: got %0d active cycles want 0", stray); end
      step();
      set_win(1, 5, 9);
      ack_log.delete(); res_log.delete(); rd_log.delete();
      req_valid = 4'b0010;
      run_sched(1, 40, to);
      checks++;
      if (to) begin failures++; $display("FAIL rst_after: no result for new request"); return; end
      ref_scan(5, 9, mx, mxp, mn, mnp);
      checks++;
      if (res_log[0].cyc - ack_log[0].cyc != 7 || res_log[0].mx != mx || res_log[0].mnp != mnp)
         begin failures++; $display("FAIL rst_after_vals: latency %0d max %0d minpos %0d want 7/%0d/%0d", res_log[0].cyc - ack_log[0].cyc, res_log[0].mx, res_log[0].mnp, mx, mnp); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_t();
      test_err();
      test_single_sample();
      test_all_four();
      test_random();
      test_enable_abort();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
